hazard_scoreboard: RTL

//   Parametrised hazard-detection and forwarding-control unit for the in-order MIPS pipeline. Sits beside
//   the ID stage: tracks destinations of in-flight instructions (EX..WB) in a shift-register scoreboard,

---
 rtl/hazard_scoreboard.sv | 105 ++++++++++
 1 files changed

// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - hazard detection and forwarding control for the in-order pipeline
// Tracks in-flight destinations in a shift-register scoreboard; stalls ID or emits EX bypass selects.
module hazard_scoreboard #(
  parameter int REG_ADDR_W = 5,
  parameter int NUM_SRC    = 2,
  parameter int PIPE_DEPTH = 3,
  parameter int LOAD_LAT   = 1,
  parameter int CNT_W      = 16,
  localparam int SEL_W     = (PIPE_DEPTH > 1) ? $clog2(PIPE_DEPTH) : 1
) (
  input  logic                          Clk,
  input  logic                          Rst_n,
  input  logic                          id_valid,
  input  logic [NUM_SRC*REG_ADDR_W-1:0] id_src,
  input  logic [NUM_SRC-1:0]            id_src_used,
  input  logic [REG_ADDR_W-1:0]         id_rd,
  input  logic                          id_reg_write,
  input  logic                          id_is_load,
  input  logic                          pipe_hold,
  input  logic                          flush,
  output logic                          stall,
  output logic [NUM_SRC*SEL_W-1:0]      ex_fwd_sel,
  output logic [CNT_W-1:0]              stall_count
);

  logic [PIPE_DEPTH-1:0] ent_vld;
  logic [REG_ADDR_W-1:0] ent_rd  [PIPE_DEPTH];
  logic [SEL_W-1:0]      ent_rdy [PIPE_DEPTH];

  logic                     hazard;
  logic                     issue;
  logic [NUM_SRC*SEL_W-1:0] sel_next;
  logic                     new_vld;
  logic [SEL_W-1:0]         new_rdy;

  always_comb begin : hazard_check
    logic [REG_ADDR_W-1:0] spec;
    logic                  found;
    int                    hit;
    logic [SEL_W-1:0]      hit_rdy;
    hazard   = 1'b0;
    sel_next = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      spec    = id_src[i*REG_ADDR_W +: REG_ADDR_W];
      found   = 1'b0;
      hit     = 0;
      hit_rdy = '0;
      // Scan oldest to youngest so the youngest matching producer wins.
      for (int k = PIPE_DEPTH - 1; k >= 0; k--) begin
        if (ent_vld[k] && (ent_rd[k] == spec)) begin
          found   = 1'b1;
          hit     = k;
          hit_rdy = ent_rdy[k];
        end
      end
      if (id_src_used[i] && (spec != '0) && found) begin
        if (hit + 1 >= PIPE_DEPTH) begin
          sel_next[i*SEL_W +: SEL_W] = '0;
        end else if (hit + 1 >= int'(hit_rdy)) begin
          sel_next[i*SEL_W +: SEL_W] = SEL_W'(hit + 1);
        end else begin
          hazard = 1'b1;
        end
      end
    end
  end

  assign stall   = id_valid & ~flush & hazard;
  assign issue   = id_valid & ~flush & ~hazard;
  assign new_vld = id_reg_write && (id_rd != '0);
  assign new_rdy = id_is_load ? SEL_W'(1 + LOAD_LAT) : SEL_W'(1);

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      ent_vld     <= '0;
      ex_fwd_sel  <= '0;
      stall_count <= '0;
      for (int k = 0; k < PIPE_DEPTH; k++) begin
        ent_rd[k]  <= '0;
        ent_rdy[k] <= '0;
      end
    end else if (!pipe_hold) begin
      for (int k = PIPE_DEPTH - 1; k > 0; k--) begin
        ent_vld[k] <= ent_vld[k-1];
        ent_rd[k]  <= ent_rd[k-1];
        ent_rdy[k] <= ent_rdy[k-1];
      end
      if (issue) begin
        ent_vld[0] <= new_vld;
        ent_rd[0]  <= id_rd;
        ent_rdy[0] <= new_rdy;
        ex_fwd_sel <= sel_next;
      end else begin
        ent_vld[0] <= 1'b0;
        ent_rd[0]  <= '0;
        ent_rdy[0] <= '0;
        ex_fwd_sel <= '0;
      end
      if (stall && (stall_count != {CNT_W{1'b1}})) begin
        stall_count <= stall_count + 1'b1;
      end
    end
  end

endmodule
